// File: rtl/sub_nibble_seq_if.sv
// sub_nibble_seq_if: operand/result handshake plus the shared 4-bit subtractor link
interface sub_nibble_seq_if #(parameter int NIBBLES = 4);
  logic start, Bin, busy, done, Bout, sub_bin, sub_bout;
  logic [4*NIBBLES-1:0] X, Y, Diff;
  logic [3:0] sub_x, sub_y, sub_diff;
  modport master (
    output start, X, Y, Bin, sub_diff, sub_bout,
    input  busy, done, Diff, Bout, sub_x, sub_y, sub_bin
  );
  modport slave (
    input  start, X, Y, Bin, sub_diff, sub_bout,
    output busy, done, Diff, Bout, sub_x, sub_y, sub_bin
  );
endinterface

// File: rtl/sub_nibble_seq.sv
// sub_nibble_seq: multi-nibble X - Y - Bin computed one nibble per clock through one external 4-bit subtractor
module sub_nibble_seq #(parameter int NIBBLES = 4) (
  input logic clk,
  input logic rst_n,
  sub_nibble_seq_if.slave bus
);
  localparam int W  = 4*NIBBLES;
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [W-1:0] xr_q, yr_q, acc_q, acc_d, diff_q;
  logic brw_q, bout_q, accept, last;
  logic [IW-1:0] idx_q;
  assign accept = bus.start && state_q != RUN;
  assign last   = idx_q == IW'(NIBBLES-1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = state_q == RUN ? (last ? DONE : RUN) : (bus.start ? RUN : IDLE);
  // accumulator with the current nibble merged in; feeds both acc_q and the final Diff
  always_comb begin
    acc_d = acc_q;
    acc_d[4*idx_q +: 4] = bus.sub_diff;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      xr_q   <= '0;
      yr_q   <= '0;
      acc_q  <= '0;
      diff_q <= '0;
      brw_q  <= 1'b0;
      bout_q <= 1'b0;
      idx_q  <= '0;
    end else if (accept) begin
      xr_q  <= bus.X;
      yr_q  <= bus.Y;
      brw_q <= bus.Bin;
      acc_q <= '0;
      idx_q <= '0;
    end else if (state_q == RUN) begin
      acc_q <= acc_d;
      brw_q <= bus.sub_bout;
      idx_q <= idx_q + IW'(1);
      if (last) begin
        diff_q <= acc_d;
        bout_q <= bus.sub_bout;
      end
    end
  always_comb begin
    bus.busy    = state_q == RUN;
    bus.done    = state_q == DONE;
    bus.Diff    = diff_q;
    bus.Bout    = bout_q;
    bus.sub_x   = state_q == RUN ? xr_q[4*idx_q +: 4] : 4'd0;
    bus.sub_y   = state_q == RUN ? yr_q[4*idx_q +: 4] : 4'd0;
    bus.sub_bin = state_q == RUN && brw_q;
  end
endmodule
